// File: rtl/main_control_fsm_if.sv
// rtl/main_control_fsm_if.sv - control-unit bundle: opcode/memory handshake in, datapath enables and selects out
interface main_control_fsm_if;
    logic [5:0] Op;
    logic       MemReady;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       IllegalOp;
    logic [3:0] State;

    modport master (
        input  Op, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, IllegalOp, State
    );

    modport slave (
        output Op, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, IllegalOp, State
    );
endinterface

// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multi-cycle CPU main control sequencer with memory-ready stalls
module main_control_fsm (
    input  logic                    clk,
    input  logic                    rst,
    main_control_fsm_if.master      bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ILLEGAL = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    state_t     state_q;
    state_t     state_next;
    logic [5:0] op;
    logic       mem_ready;

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;

    assign op        = bus.Op;
    assign mem_ready = bus.MemReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next    = S_FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                state_next = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read   = 1'b1;
                i_or_d     = 1'b1;
                state_next = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                state_next = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                state_next = S_RWB;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_ILLEGAL: begin
                illegal_op = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase

        // Reset silences every enable immediately, not just from the next edge.
        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            pc_source     = 2'b00;
            illegal_op    = 1'b0;
        end
    end

    assign bus.PCWrite     = pc_write;
    assign bus.PCWriteCond = pc_write_cond;
    assign bus.IorD        = i_or_d;
    assign bus.MemRead     = mem_read;
    assign bus.MemWrite    = mem_write;
    assign bus.IRWrite     = ir_write;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.RegDst      = reg_dst;
    assign bus.RegWrite    = reg_write;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.ALUOp       = alu_op;
    assign bus.PCSource    = pc_source;
    assign bus.IllegalOp   = illegal_op;
    assign bus.State       = rst ? 4'd0 : state_q;
endmodule

// File: tb/tb_main_control_fsm.sv
// tb/tb_main_control_fsm.sv - randomized instruction stream against a per-instruction step model
module tb_main_control_fsm;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   ir_pulses;

    main_control_fsm_if bus ();

    main_control_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, want finish before 2ms");
        $fatal(1);
    end

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,IllegalOp}
    logic [16:0] ctrl_vec;
    assign ctrl_vec = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                       bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                       bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.IllegalOp};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [16:0] expected_ctrl(input int phase, input logic rdy);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, ill;
        logic [1:0] asb, aop, pcs;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, ill} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (phase)
            0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: ill = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill};
    endfunction

    function automatic logic [5:0] rand_op();
        return 6'($urandom_range(0, 63));
    endfunction

    task automatic step(input int phase, input logic rdy, input logic [5:0] op_v);
        bus.Op       = op_v;
        bus.MemReady = rdy;
        @(negedge clk);
        check_val($sformatf("state@%0d", phase), 32'(bus.State), 32'(phase));
        check_val($sformatf("ctrl@%0d", phase), 32'(ctrl_vec), 32'(expected_ctrl(phase, rdy)));
        if (bus.IRWrite) ir_pulses++;
        @(posedge clk);
        #1;
    endtask

    task automatic mem_wait(input int phase, input int stalls);
        for (int i = 0; i <= stalls; i++) step(phase, (i == stalls), rand_op());
    endtask

    task automatic run_instr(input logic [5:0] op, input int fetch_stalls, input int mem_stalls);
        ir_pulses = 0;
        mem_wait(0, fetch_stalls);
        step(1, 1'($urandom_range(0, 1)), op);
        case (op)
            6'd35: begin
                step(2, 1'($urandom_range(0, 1)), op);
                mem_wait(3, mem_stalls);
                step(4, 1'($urandom_range(0, 1)), rand_op());
            end
            6'd43: begin
                step(2, 1'($urandom_range(0, 1)), op);
                mem_wait(5, mem_stalls);
            end
            6'd0: begin
                step(6, 1'($urandom_range(0, 1)), rand_op());
                step(7, 1'($urandom_range(0, 1)), rand_op());
            end
            6'd4:    step(8, 1'($urandom_range(0, 1)), rand_op());
            6'd2:    step(9, 1'($urandom_range(0, 1)), rand_op());
            default: step(10, 1'($urandom_range(0, 1)), rand_op());
        endcase
        check_val("ir_pulses", 32'(ir_pulses), 32'd1);
    endtask

    task automatic check_reset_cycle();
        bus.Op       = rand_op();
        bus.MemReady = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_val("rst_state", 32'(bus.State), 32'd0);
        check_val("rst_ctrl", 32'(ctrl_vec), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] legal [5];
        total = 0;
        bad   = 0;
        ir_pulses = 0;
        legal[0] = 6'd0; legal[1] = 6'd35; legal[2] = 6'd43; legal[3] = 6'd4; legal[4] = 6'd2;

        rst          = 1'b1;
        bus.Op       = 6'd0;
        bus.MemReady = 1'b0;
        check_reset_cycle();
        check_reset_cycle();
        rst = 1'b0;

        run_instr(6'd35, 0, 0);
        run_instr(6'd43, 0, 3);
        run_instr(6'd0, 0, 0);
        run_instr(6'd4, 0, 0);
        run_instr(6'd2, 0, 0);
        run_instr(6'd63, 0, 0);
        run_instr(6'd35, 2, 2);

        // Reset in the middle of a stalled load, then resume from a clean fetch.
        ir_pulses = 0;
        step(0, 1'b1, rand_op());
        step(1, 1'b0, 6'd35);
        step(2, 1'b0, 6'd35);
        step(3, 1'b0, rand_op());
        rst = 1'b1;
        check_reset_cycle();
        check_reset_cycle();
        rst = 1'b0;
        run_instr(6'd35, 1, 1);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                do op = rand_op();
                while (op == 6'd0 || op == 6'd2 || op == 6'd4 || op == 6'd35 || op == 6'd43);
            end else begin
                op = legal[$urandom_range(0, 4)];
            end
            run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multi-cycle main control unit for the simple CPU. It steps through fetch, decode, execute, memory and writeback. It generates every datapath enable and select, and drives the 2-bit ALUOp that the ALU control decoder consumes. ALUOp encoding is 00 = add, 01 = subtract, 10 = use function code. Memory accesses stall on a ready handshake, so one sequencer serves both single-cycle and wait-stated memory.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- Op  input  6  opcode, instruction[31:26], from the instruction register
- MemReady  input  1  memory completes current read/write this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if ALU Zero
- IorD  output  1  memory address source: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  register write data: 0 = ALUOut, 1 = MDR
- RegDst  output  1  destination register: 0 = rt, 1 = rd
- RegWrite  output  1  register file write
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- ALUOp  output  2  to ALU control decoder
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- IllegalOp  output  1  unsupported opcode pulse
- State  output  4  current state code, for debug

## Operation
- Opcodes: 0 = R-type, 35 = lw, 43 = sw, 4 = beq, 2 = j. Any other value is illegal.
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ILLEGAL=10. Codes 11–15 are unreachable; if ever entered, next state is FETCH.
- Outputs are a Moore decode of State, except IRWrite and PCWrite in FETCH, which also depend on MemReady. Any output not listed for a state is 0.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=MemReady, PCWrite=MemReady.
  - Next: DECODE when MemReady=1, else stay in FETCH.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next, on the Op sampled this cycle: 35 or 43 -> MEMADR; 0 -> EXEC; 4 -> BRANCH; 2 -> JUMP; otherwise ILLEGAL.
- MEMADR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next: Op=35 -> MEMRD, else MEMWR.
- MEMRD:
  - Outputs: MemRead=1, IorD=1.
  - Next: MEMWB when MemReady=1, else stay.
- MEMWB:
  - Outputs: RegWrite=1, MemtoReg=1, RegDst=0.
  - Next: FETCH.
- MEMWR:
  - Outputs: MemWrite=1, IorD=1.
  - Next: FETCH when MemReady=1, else stay.
- EXEC:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Next: RWB.
- RWB:
  - Outputs: RegWrite=1, RegDst=1, MemtoReg=0.
  - Next: FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - Next: FETCH.
- JUMP:
  - Outputs: PCWrite=1, PCSource=10.
  - Next: FETCH.
- ILLEGAL:
  - Outputs: IllegalOp=1 for exactly one cycle. No write enable is asserted.
  - Next: FETCH, so the bad word is skipped because PC already advanced.
- Op is only examined in DECODE and MEMADR. Changes on Op in other states have no effect.
- MemReady is only examined in FETCH, MEMRD and MEMWR. It is ignored elsewhere.

## Timing
- Reset:
  - While rst=1 at a clock edge, State becomes FETCH.
  - While rst=1, all outputs are forced to 0 combinationally, including MemRead and State.
  - First fetch request appears in the first cycle after rst is sampled low.
- Reset mid-instruction: discards the in-progress instruction. No partial writes occur after the reset edge.
- Cycle counts, with MemReady=1 on first request:
  - lw = 5 cycles
  - sw = 4 cycles
  - R-type = 4 cycles
  - beq = 3 cycles
  - j = 3 cycles
  - illegal = 3 cycles
- Each wait cycle on FETCH, MEMRD or MEMWR adds exactly one cycle.
- MemRead/MemWrite stay asserted and IorD stays stable throughout a stall.
- IRWrite and PCWrite pulse exactly once per fetch, in the cycle MemReady=1.
- ALUOp is valid in the same cycle as its state. The ALU control decoder is combinational, so ALUCtl is valid in that cycle.

## Test plan
- Reset then lw (Op=35), MemReady held 1:
  - State sequence 0,1,2,3,4,0.
  - RegWrite=1 and MemtoReg=1 only in state 4.
  - IRWrite high exactly one cycle.
- sw (Op=43), MemReady low for 3 cycles in MEMWR:
  - State sequence 0,1,2,5,5,5,5,0.
  - MemWrite=1 and IorD=1 for all 4 MEMWR cycles.
- R-type (Op=0) then beq (Op=4):
  - R-type shows ALUOp=10 in EXEC, then RegDst=1 and RegWrite=1 in RWB.
  - beq shows ALUOp=01 with PCWriteCond=1 and PCSource=01 in BRANCH.
  - Fetch-to-fetch spacing is 4 and 3 cycles.
- j (Op=2):
  - PCWrite=1 and PCSource=10 for one cycle in JUMP.
  - FETCH follows.
- Illegal Op=63:
  - State sequence 0,1,10,0.
  - IllegalOp=1 for one cycle.
  - RegWrite, MemWrite and PCWriteCond never asserted.
- Assert rst during MEMRD stall with MemReady=0:
  - Next State=0 and all outputs 0 while rst=1.
  - After release, FETCH with MemRead=1 and IorD=0.
